smol_rf_operand_fetch: RTL and testbench

- Initiator side of the smolRF access interface.
- Accepts decoded instructions with source/destination register indices and drives the smolRF read ports.
- Returns 32-bit operands to execute, and passes writeback requests onto the smolRF write port.
- Tracks pending writes in a 32-entry scoreboard, stalls on RAW hazards, and forwards writeback data that collides with an operand read.

---
 rtl/smol_rf_operand_fetch_pkg.sv | 39 +++
 rtl/smol_rf_operand_fetch_if.sv | 57 +++++
 rtl/smol_rf_operand_fetch_scoreboard.sv | 47 ++++
 rtl/smol_rf_operand_fetch.sv | 155 +++++++++++++++
 tb/tb_smol_rf_operand_fetch.sv | 335 +++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/smol_rf_operand_fetch_pkg.sv
// Shared widths, types and FSM encoding for the smolRF operand-fetch block.
// Pure declarations: no latency, no flow control.
package smol_rf_operand_fetch_pkg;

  localparam int XLEN   = 32;
  localparam int NREGS  = 32;
  localparam int REG_AW = $clog2(NREGS);

  typedef logic [REG_AW-1:0] reg_addr_t;
  typedef logic [XLEN-1:0]   word_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    READ = 2'd1,
    HOLD = 2'd2
  } fetch_state_t;

  // True when a writeback in this cycle targets a real source register.
  function automatic logic wb_hits(input logic wb_vld, input reg_addr_t wb_addr,
                                   input reg_addr_t rs);
    return wb_vld && (wb_addr == rs) && (rs != '0);
  endfunction

  // x0 and unused sources read as zero; a captured writeback beats the stale RF read.
  function automatic word_t sel_operand(input logic use_src, input reg_addr_t rs,
                                        input logic byp, input word_t byp_dat,
                                        input word_t rf_dat);
    word_t op;
    if (!use_src || (rs == '0)) begin
      op = '0;
    end else if (byp) begin
      op = byp_dat;
    end else begin
      op = rf_dat;
    end
    return op;
  endfunction

endpackage

// File: rtl/smol_rf_operand_fetch_if.sv
// Bundles the issue, execute, writeback and smolRF port signals of the fetch block.
// master = operand-fetch side, slave = surrounding pipeline and register file.
interface smol_rf_operand_fetch_if;
  import smol_rf_operand_fetch_pkg::*;

  logic      in_valid;
  logic      in_ready;
  reg_addr_t in_rs1;
  reg_addr_t in_rs2;
  reg_addr_t in_rd;
  logic      in_use_rs1;
  logic      in_use_rs2;
  logic      in_wr_rd;

  logic      out_valid;
  logic      out_ready;
  word_t     out_op1;
  word_t     out_op2;
  reg_addr_t out_rd;

  logic      wb_valid;
  reg_addr_t wb_addr;
  word_t     wb_data;

  logic      rf_wEnable;
  reg_addr_t rf_wAddr;
  word_t     rf_wData;
  logic      rf_rEnable1;
  logic      rf_rEnable2;
  reg_addr_t rf_rAddr1;
  reg_addr_t rf_rAddr2;
  word_t     rf_rData1;
  word_t     rf_rData2;

  modport master (
    input  in_valid, in_rs1, in_rs2, in_rd, in_use_rs1, in_use_rs2, in_wr_rd,
    output in_ready,
    output out_valid, out_op1, out_op2, out_rd,
    input  out_ready,
    input  wb_valid, wb_addr, wb_data,
    output rf_wEnable, rf_wAddr, rf_wData,
    output rf_rEnable1, rf_rEnable2, rf_rAddr1, rf_rAddr2,
    input  rf_rData1, rf_rData2
  );

  modport slave (
    output in_valid, in_rs1, in_rs2, in_rd, in_use_rs1, in_use_rs2, in_wr_rd,
    input  in_ready,
    input  out_valid, out_op1, out_op2, out_rd,
    output out_ready,
    output wb_valid, wb_addr, wb_data,
    input  rf_wEnable, rf_wAddr, rf_wData,
    input  rf_rEnable1, rf_rEnable2, rf_rAddr1, rf_rAddr2,
    output rf_rData1, rf_rData2
  );

endinterface

// File: rtl/smol_rf_operand_fetch_scoreboard.sv
// Pending-write scoreboard: one busy bit per register, set on issue, cleared on writeback.
// Lookups are combinational and already see this cycle's writeback; no backpressure.
module smol_scoreboard
  import smol_rf_operand_fetch_pkg::*;
(
  input  logic      clk,
  input  logic      rst,
  input  logic      i_set_vld,
  input  reg_addr_t i_set_idx,
  input  logic      i_clr_vld,
  input  reg_addr_t i_clr_idx,
  input  reg_addr_t i_look1_idx,
  input  reg_addr_t i_look2_idx,
  output logic      o_look1_busy,
  output logic      o_look2_busy
);

  logic [NREGS-1:0] r_busy;
  logic [NREGS-1:0] w_set_mask;
  logic [NREGS-1:0] w_clr_mask;
  logic [NREGS-1:0] w_busy_nxt;

  always_comb begin
    w_set_mask = '0;
    w_clr_mask = '0;
    if (i_set_vld && (i_set_idx != '0)) begin
      w_set_mask[i_set_idx] = 1'b1;
    end
    if (i_clr_vld) begin
      w_clr_mask[i_clr_idx] = 1'b1;
    end
    // Set is applied after clear so a new producer outlives the old one's writeback.
    w_busy_nxt = (r_busy & ~w_clr_mask) | w_set_mask;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_busy <= '0;
    end else begin
      r_busy <= w_busy_nxt;
    end
  end

  assign o_look1_busy = r_busy[i_look1_idx] && !w_clr_mask[i_look1_idx];
  assign o_look2_busy = r_busy[i_look2_idx] && !w_clr_mask[i_look2_idx];

endmodule

// File: rtl/smol_rf_operand_fetch.sv
// Operand fetch: issue to smolRF read ports, hazard stall, writeback forwarding and pass-through.
// Accept at edge N gives out_valid at N+2; in_ready drops on RAW hazards and outside IDLE.
module smol_rf_operand_fetch
  import smol_rf_operand_fetch_pkg::*;
(
  input logic                     clk,
  input logic                     rst,
  smol_rf_operand_fetch_if.master bus
);

  fetch_state_t r_state;
  fetch_state_t w_state_nxt;

  reg_addr_t r_rs1;
  reg_addr_t r_rs2;
  logic      r_use1;
  logic      r_use2;
  reg_addr_t r_rd;
  logic      r_byp1;
  logic      r_byp2;
  word_t     r_bypdat1;
  word_t     r_bypdat2;

  logic      r_out_vld;
  word_t     r_op1;
  word_t     r_op2;
  reg_addr_t r_out_rd;

  logic w_src1_pend;
  logic w_src2_pend;
  logic w_haz;
  logic w_in_rdy;
  logic w_accept;
  logic w_ren1;
  logic w_ren2;
  logic w_load_out;
  logic w_out_vld_nxt;

  smol_scoreboard u_scoreboard (
    .clk          (clk),
    .rst          (rst),
    .i_set_vld    (w_accept && bus.in_wr_rd),
    .i_set_idx    (bus.in_rd),
    .i_clr_vld    (bus.wb_valid),
    .i_clr_idx    (bus.wb_addr),
    .i_look1_idx  (bus.in_rs1),
    .i_look2_idx  (bus.in_rs2),
    .o_look1_busy (w_src1_pend),
    .o_look2_busy (w_src2_pend)
  );

  // A source being written back this cycle is not a hazard: it is captured as a bypass.
  assign w_haz = (bus.in_use_rs1 && (bus.in_rs1 != '0) && w_src1_pend) ||
                 (bus.in_use_rs2 && (bus.in_rs2 != '0) && w_src2_pend);

  always_comb begin
    w_state_nxt   = r_state;
    w_in_rdy      = 1'b0;
    w_accept      = 1'b0;
    w_ren1        = 1'b0;
    w_ren2        = 1'b0;
    w_load_out    = 1'b0;
    w_out_vld_nxt = r_out_vld;
    unique case (r_state)
      IDLE: begin
        w_in_rdy = !w_haz;
        w_ren1   = bus.in_valid && bus.in_use_rs1 && !w_haz;
        w_ren2   = bus.in_valid && bus.in_use_rs2 && !w_haz;
        w_accept = bus.in_valid && !w_haz;
        if (w_accept) begin
          w_state_nxt = READ;
        end
      end
      READ: begin
        w_load_out    = 1'b1;
        w_out_vld_nxt = 1'b1;
        w_state_nxt   = HOLD;
      end
      HOLD: begin
        if (bus.out_ready) begin
          w_out_vld_nxt = 1'b0;
          w_state_nxt   = IDLE;
        end
      end
      default: begin
        w_out_vld_nxt = 1'b0;
        w_state_nxt   = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_rs1     <= '0;
      r_rs2     <= '0;
      r_use1    <= 1'b0;
      r_use2    <= 1'b0;
      r_rd      <= '0;
      r_byp1    <= 1'b0;
      r_byp2    <= 1'b0;
      r_bypdat1 <= '0;
      r_bypdat2 <= '0;
    end else if (w_accept) begin
      r_rs1     <= bus.in_rs1;
      r_rs2     <= bus.in_rs2;
      r_use1    <= bus.in_use_rs1;
      r_use2    <= bus.in_use_rs2;
      r_rd      <= bus.in_rd;
      r_byp1    <= wb_hits(bus.wb_valid, bus.wb_addr, bus.in_rs1);
      r_byp2    <= wb_hits(bus.wb_valid, bus.wb_addr, bus.in_rs2);
      r_bypdat1 <= bus.wb_data;
      r_bypdat2 <= bus.wb_data;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_out_vld <= 1'b0;
      r_op1     <= '0;
      r_op2     <= '0;
      r_out_rd  <= '0;
    end else begin
      r_out_vld <= w_out_vld_nxt;
      if (w_load_out) begin
        r_op1    <= sel_operand(r_use1, r_rs1, r_byp1, r_bypdat1, bus.rf_rData1);
        r_op2    <= sel_operand(r_use2, r_rs2, r_byp2, r_bypdat2, bus.rf_rData2);
        r_out_rd <= r_rd;
      end
    end
  end

  assign bus.in_ready    = w_in_rdy;
  assign bus.out_valid   = r_out_vld;
  assign bus.out_op1     = r_op1;
  assign bus.out_op2     = r_op2;
  assign bus.out_rd      = r_out_rd;

  assign bus.rf_wEnable  = bus.wb_valid && (bus.wb_addr != '0);
  assign bus.rf_wAddr    = bus.wb_addr;
  assign bus.rf_wData    = bus.wb_data;

  assign bus.rf_rEnable1 = w_ren1;
  assign bus.rf_rEnable2 = w_ren2;
  assign bus.rf_rAddr1   = bus.in_rs1;
  assign bus.rf_rAddr2   = bus.in_rs2;

endmodule

// File: tb/tb_smol_rf_operand_fetch.sv
// Bench for smol_rf_operand_fetch: write-path table, directed hazard/bypass/hold/reset
// sequences, then random traffic against an architectural register/pending-set model.
module tb_smol_rf_operand_fetch;
  import smol_rf_operand_fetch_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   n_checks = 0;
  int   n_errors = 0;

  always #5 clk = ~clk;

  smol_rf_operand_fetch_if bus();

  smol_rf_operand_fetch dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // smolRF: registered reads, writes commit at the edge, read-during-write returns old data.
  word_t rf_mem [NREGS];
  always @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < NREGS; i++) rf_mem[i] <= '0;
      bus.rf_rData1 <= '0;
      bus.rf_rData2 <= '0;
    end else begin
      if (bus.rf_rEnable1) bus.rf_rData1 <= rf_mem[bus.rf_rAddr1];
      if (bus.rf_rEnable2) bus.rf_rData2 <= rf_mem[bus.rf_rAddr2];
      if (bus.rf_wEnable) rf_mem[bus.rf_wAddr] <= bus.rf_wData;
    end
  end

  typedef struct {
    logic      vld;
    reg_addr_t addr;
    word_t     dat;
    logic      exp_wen;
  } wb_vec_t;

  wb_vec_t wb_tab [6];

  // Reference model state
  int               phase;       // 0 waiting for issue, 1 reading, 2 presenting
  logic [NREGS-1:0] pend;
  word_t            arch [NREGS];
  word_t            e_op1;
  word_t            e_op2;
  reg_addr_t        e_rd;
  logic             have_inst;
  logic             haz;
  logic             exp_rdy;
  logic             acc;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: actual 0x%0h required 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    bus.in_valid   = 1'b0;
    bus.in_rs1     = '0;
    bus.in_rs2     = '0;
    bus.in_rd      = '0;
    bus.in_use_rs1 = 1'b0;
    bus.in_use_rs2 = 1'b0;
    bus.in_wr_rd   = 1'b0;
    bus.out_ready  = 1'b0;
    bus.wb_valid   = 1'b0;
    bus.wb_addr    = '0;
    bus.wb_data    = '0;
  endtask

  task automatic issue(input reg_addr_t rs1, input logic u1, input reg_addr_t rs2,
                       input logic u2, input reg_addr_t rd, input logic wr);
    bus.in_valid   = 1'b1;
    bus.in_rs1     = rs1;
    bus.in_use_rs1 = u1;
    bus.in_rs2     = rs2;
    bus.in_use_rs2 = u2;
    bus.in_rd      = rd;
    bus.in_wr_rd   = wr;
  endtask

  task automatic wb(input logic v, input reg_addr_t a, input word_t d);
    bus.wb_valid = v;
    bus.wb_addr  = a;
    bus.wb_data  = d;
  endtask

  task automatic wait_out_valid(input string name);
    int n;
    n = 0;
    while (bus.out_valid !== 1'b1 && n < 20) begin
      step();
      n++;
    end
    check(name, 32'(bus.out_valid), 32'd1);
  endtask

  task automatic drain();
    bus.out_ready = 1'b1;
    step();
    bus.out_ready = 1'b0;
  endtask

  initial begin
    clear_inputs();
    wb_tab[0] = '{1'b1, 5'd1,  32'h0000_0010, 1'b1};
    wb_tab[1] = '{1'b1, 5'd0,  32'h0000_FFFF, 1'b0};
    wb_tab[2] = '{1'b0, 5'd5,  32'h0000_0055, 1'b0};
    wb_tab[3] = '{1'b1, 5'd31, 32'hDEAD_BEEF, 1'b1};
    wb_tab[4] = '{1'b1, 5'd0,  32'h0000_0000, 1'b0};
    wb_tab[5] = '{1'b1, 5'd16, 32'h0000_1234, 1'b1};

    rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("reset out_valid", 32'(bus.out_valid), 32'd0);
    check("reset out_op1", bus.out_op1, 32'd0);
    check("reset out_op2", bus.out_op2, 32'd0);
    check("reset out_rd", 32'(bus.out_rd), 32'd0);
    check("reset in_ready", 32'(bus.in_ready), 32'd1);

    // Write path is combinational; applied under reset so nothing commits.
    for (int i = 0; i < 6; i++) begin
      wb(wb_tab[i].vld, wb_tab[i].addr, wb_tab[i].dat);
      #1;
      check($sformatf("wtab%0d wEnable", i), 32'(bus.rf_wEnable), 32'(wb_tab[i].exp_wen));
      if (wb_tab[i].vld) begin
        check($sformatf("wtab%0d wAddr", i), 32'(bus.rf_wAddr), 32'(wb_tab[i].addr));
        check($sformatf("wtab%0d wData", i), bus.rf_wData, wb_tab[i].dat);
      end
    end
    clear_inputs();
    rst = 1'b1;
    step();

    // x1 = 0x10 then read it back with rs2 = x0
    wb(1'b1, 5'd1, 32'h10);
    #1;
    check("A wEnable", 32'(bus.rf_wEnable), 32'd1);
    check("A wAddr", 32'(bus.rf_wAddr), 32'd1);
    check("A wData", bus.rf_wData, 32'h10);
    step();
    wb(1'b0, '0, '0);
    issue(5'd1, 1'b1, 5'd0, 1'b1, 5'd0, 1'b0);
    #1;
    check("A in_ready", 32'(bus.in_ready), 32'd1);
    check("A rEnable1", 32'(bus.rf_rEnable1), 32'd1);
    check("A rAddr1", 32'(bus.rf_rAddr1), 32'd1);
    step();
    bus.in_valid = 1'b0;
    check("A out_valid N+1", 32'(bus.out_valid), 32'd0);
    step();
    check("A out_valid N+2", 32'(bus.out_valid), 32'd1);
    check("A op1", bus.out_op1, 32'h10);
    check("A op2", bus.out_op2, 32'h0);
    drain();
    check("A out_valid after ready", 32'(bus.out_valid), 32'd0);

    // RAW stall on x2 until its writeback, then bypass
    issue(5'd0, 1'b0, 5'd0, 1'b0, 5'd2, 1'b1);
    #1;
    step();
    bus.in_valid = 1'b0;
    wait_out_valid("B0 out_valid");
    drain();
    issue(5'd2, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0);
    for (int k = 0; k < 3; k++) begin
      #1;
      check("B stall in_ready", 32'(bus.in_ready), 32'd0);
      check("B stall rEnable1", 32'(bus.rf_rEnable1), 32'd0);
      step();
    end
    wb(1'b1, 5'd2, 32'h1);
    #1;
    check("B wb-cycle in_ready", 32'(bus.in_ready), 32'd1);
    step();
    wb(1'b0, '0, '0);
    bus.in_valid = 1'b0;
    wait_out_valid("B1 out_valid");
    check("B op1 bypass", bus.out_op1, 32'h1);
    drain();

    // Same-cycle writeback and read of x3 must not return the stale 0x99
    wb(1'b1, 5'd3, 32'h99);
    #1;
    step();
    wb(1'b1, 5'd3, 32'h2);
    issue(5'd3, 1'b1, 5'd3, 1'b1, 5'd0, 1'b0);
    #1;
    check("C in_ready", 32'(bus.in_ready), 32'd1);
    step();
    wb(1'b0, '0, '0);
    bus.in_valid = 1'b0;
    wait_out_valid("C out_valid");
    check("C op1", bus.out_op1, 32'h2);
    check("C op2", bus.out_op2, 32'h2);
    drain();

    // x0 writes dropped; x0 reads zero
    wb(1'b1, 5'd0, 32'hFFFF);
    #1;
    check("D wEnable x0", 32'(bus.rf_wEnable), 32'd0);
    step();
    wb(1'b0, '0, '0);
    issue(5'd0, 1'b1, 5'd3, 1'b1, 5'd0, 1'b0);
    #1;
    step();
    bus.in_valid = 1'b0;
    wait_out_valid("D out_valid");
    check("D op1 x0", bus.out_op1, 32'h0);
    check("D op2", bus.out_op2, 32'h2);
    drain();

    // Hold outputs stable under out_ready=0
    issue(5'd1, 1'b1, 5'd3, 1'b1, 5'd5, 1'b1);
    #1;
    step();
    bus.in_valid = 1'b0;
    wait_out_valid("E out_valid");
    issue(5'd1, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0);
    for (int k = 0; k < 5; k++) begin
      #1;
      check("E hold out_valid", 32'(bus.out_valid), 32'd1);
      check("E hold op1", bus.out_op1, 32'h10);
      check("E hold op2", bus.out_op2, 32'h2);
      check("E hold out_rd", 32'(bus.out_rd), 32'd5);
      check("E hold in_ready", 32'(bus.in_ready), 32'd0);
      step();
    end
    bus.out_ready = 1'b1;
    step();
    bus.out_ready = 1'b0;
    check("E release out_valid", 32'(bus.out_valid), 32'd0);
    #1;
    check("E release in_ready", 32'(bus.in_ready), 32'd1);
    step();
    bus.in_valid = 1'b0;
    wait_out_valid("E2 out_valid");
    check("E2 op1", bus.out_op1, 32'h10);

    // Async reset in HOLD with x5 still pending
    #1;
    rst = 1'b0;
    #1;
    check("R async out_valid", 32'(bus.out_valid), 32'd0);
    check("R async op1", bus.out_op1, 32'd0);
    step();
    rst = 1'b1;
    step();
    check("R out_valid after release", 32'(bus.out_valid), 32'd0);
    issue(5'd5, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0);
    #1;
    check("R busy cleared in_ready", 32'(bus.in_ready), 32'd1);
    bus.in_valid = 1'b0;

    // Random traffic on x0..x7 against the architectural model
    clear_inputs();
    rst = 1'b0;
    step();
    step();
    rst = 1'b1;
    step();
    phase     = 0;
    pend      = '0;
    have_inst = 1'b0;
    e_op1     = '0;
    e_op2     = '0;
    e_rd      = '0;
    for (int i = 0; i < NREGS; i++) arch[i] = '0;

    for (int cyc = 0; cyc < 3000; cyc++) begin
      if (!have_inst && $urandom_range(0, 2) != 0) begin
        issue(5'($urandom_range(0, 7)), 1'($urandom_range(0, 1)),
              5'($urandom_range(0, 7)), 1'($urandom_range(0, 1)),
              5'($urandom_range(0, 7)), 1'($urandom_range(0, 1)));
        have_inst = 1'b1;
      end
      wb(1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)), $urandom);
      bus.out_ready = ($urandom_range(0, 3) != 0);
      #1;
      haz = (bus.in_use_rs1 && bus.in_rs1 != 0 && pend[bus.in_rs1] &&
             !(bus.wb_valid && bus.wb_addr == bus.in_rs1)) ||
            (bus.in_use_rs2 && bus.in_rs2 != 0 && pend[bus.in_rs2] &&
             !(bus.wb_valid && bus.wb_addr == bus.in_rs2));
      exp_rdy = (phase == 0) && !haz;
      check("rnd in_ready", 32'(bus.in_ready), 32'(exp_rdy));
      check("rnd rEnable1", 32'(bus.rf_rEnable1), 32'(exp_rdy && bus.in_valid && bus.in_use_rs1));
      check("rnd rEnable2", 32'(bus.rf_rEnable2), 32'(exp_rdy && bus.in_valid && bus.in_use_rs2));
      check("rnd wEnable", 32'(bus.rf_wEnable), 32'(bus.wb_valid && bus.wb_addr != 0));
      check("rnd out_valid", 32'(bus.out_valid), 32'(phase == 2));
      if (phase == 2) begin
        check("rnd op1", bus.out_op1, e_op1);
        check("rnd op2", bus.out_op2, e_op2);
        check("rnd out_rd", 32'(bus.out_rd), 32'(e_rd));
      end

      acc = exp_rdy && bus.in_valid;
      if (bus.wb_valid) begin
        if (bus.wb_addr != 0) arch[bus.wb_addr] = bus.wb_data;
        pend[bus.wb_addr] = 1'b0;
      end
      if (acc) begin
        e_op1 = (bus.in_use_rs1 && bus.in_rs1 != 0) ? arch[bus.in_rs1] : '0;
        e_op2 = (bus.in_use_rs2 && bus.in_rs2 != 0) ? arch[bus.in_rs2] : '0;
        e_rd  = bus.in_rd;
        if (bus.in_wr_rd && bus.in_rd != 0) pend[bus.in_rd] = 1'b1;
      end
      if (phase == 0 && acc) phase = 1;
      else if (phase == 1) phase = 2;
      else if (phase == 2 && bus.out_ready) phase = 0;

      step();
      if (acc) begin
        bus.in_valid = 1'b0;
        have_inst    = 1'b0;
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
